// File: rtl/neuron_pkg.sv
// neuron_pkg: shared state encodings, Q8.8 constants and helpers for layer blocks.
`default_nettype none

package neuron_pkg;

    typedef enum logic [1:0] {
        ST_ARG = 2'd0,
        ST_RES = 2'd1,
        ST_ERR = 2'd2,
        ST_UPD = 2'd3
    } state_t;

    localparam int                 FRAC    = 8;
    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/neuron_saturate.sv
// neuron_saturate: clamps a signed IW-bit value to the signed 16-bit range.
`default_nettype none

module neuron_saturate
    import neuron_pkg::*;
#(
    parameter int IW = 24
) (
    input  logic signed [IW-1:0] i_din,
    output logic signed [15:0]   o_dout
);

    localparam logic signed [IW-1:0] C_MAX = IW'(SAT_MAX);
    localparam logic signed [IW-1:0] C_MIN = IW'(SAT_MIN);

    always_comb begin
        if (i_din > C_MAX)      o_dout = SAT_MAX;
        else if (i_din < C_MIN) o_dout = SAT_MIN;
        else                    o_dout = i_din[15:0];
    end

endmodule

`default_nettype wire

// File: rtl/neuron.sv
// neuron: serial MAC of N activations against signed weights plus bias, with
// optional in-place weight/bias update from the activation stage's delta.
`default_nettype none

module neuron
    import neuron_pkg::*;
#(
    parameter int N    = 4,
    parameter int RATE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        arg_stb,
    input  logic [7:0]  arg_dat,
    output logic        arg_rdy,
    output logic        res_stb,
    output logic [15:0] res_dat,
    input  logic        res_rdy,
    input  logic        err_stb,
    input  logic [15:0] err_dat,
    output logic        err_rdy
);

    localparam int XW   = (clog2(N) < 1) ? 1 : clog2(N);
    localparam int IDXW = clog2(N + 1);
    localparam int AW   = 24 + clog2(N) + 1;
    localparam int RW   = AW + 1 - FRAC;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDXW-1:0]          r_idx;
    logic signed [AW-1:0]     r_acc;
    logic [7:0]               r_x [N];
    logic signed [15:0]       r_w [N];
    logic signed [15:0]       r_b;
    logic signed [15:0]       r_delta;
    logic                     r_res_stb;
    logic [15:0]              r_res_dat;

    logic                     w_arg_ack;
    logic                     w_res_ack;
    logic                     w_err_ack;
    logic [XW-1:0]            w_eidx;
    logic signed [24:0]       w_prod;
    logic signed [AW:0]       w_sum;
    logic signed [15:0]       w_res_sat;
    logic signed [24:0]       w_dx;
    logic signed [24:0]       w_dx_sh;
    logic signed [25:0]       w_wnew;
    logic signed [15:0]       w_wsat;
    logic signed [15:0]       w_dsh;
    logic signed [16:0]       w_bnew;
    logic signed [15:0]       w_bsat;

    // Ready lines are gated by reset so they drop as soon as reset asserts.
    assign arg_rdy = rst && (r_state == ST_ARG);
    assign err_rdy = rst && (r_state == ST_ERR);
    assign res_stb = r_res_stb;
    assign res_dat = r_res_dat;

    assign w_arg_ack = arg_stb && arg_rdy;
    assign w_res_ack = r_res_stb && res_rdy;
    assign w_err_ack = err_stb && err_rdy;
    assign w_eidx    = r_idx[XW-1:0];

    assign w_prod  = $signed({1'b0, arg_dat}) * r_w[w_eidx];
    assign w_sum   = {r_acc[AW-1], r_acc} + ({{(AW+1-16){r_b[15]}}, r_b} <<< FRAC);
    assign w_dx    = r_delta * $signed({1'b0, r_x[w_eidx]});
    assign w_dx_sh = w_dx >>> (FRAC + RATE);
    assign w_wnew  = {{10{r_w[w_eidx][15]}}, r_w[w_eidx]} - {w_dx_sh[24], w_dx_sh};
    assign w_dsh   = r_delta >>> RATE;
    assign w_bnew  = {r_b[15], r_b} - {w_dsh[15], w_dsh};

    neuron_saturate #(.IW(RW)) u_sat_res (.i_din(w_sum[AW:FRAC]), .o_dout(w_res_sat));
    neuron_saturate #(.IW(26)) u_sat_w   (.i_din(w_wnew),         .o_dout(w_wsat));
    neuron_saturate #(.IW(17)) u_sat_b   (.i_din(w_bnew),         .o_dout(w_bsat));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_ARG;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARG: if (w_arg_ack && r_idx == IDXW'(N - 1)) w_state_nxt = ST_RES;
            ST_RES: if (w_res_ack) w_state_nxt = en ? ST_ERR : ST_ARG;
            ST_ERR: if (w_err_ack) w_state_nxt = ST_UPD;
            ST_UPD: if (r_idx == IDXW'(N)) w_state_nxt = ST_ARG;
            default: w_state_nxt = ST_ARG;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_delta   <= '0;
            r_res_stb <= 1'b0;
            r_res_dat <= '0;
            for (int i = 0; i < N; i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_ARG: if (w_arg_ack) begin
                    r_x[w_eidx] <= arg_dat;
                    r_acc       <= r_acc + AW'(w_prod);
                    r_idx       <= (r_idx == IDXW'(N - 1)) ? '0 : r_idx + 1'b1;
                end
                ST_RES: begin
                    if (!r_res_stb) begin
                        r_res_dat <= w_res_sat;
                        r_res_stb <= 1'b1;
                    end else if (res_rdy) begin
                        r_res_stb <= 1'b0;
                        r_acc     <= '0;
                    end
                end
                ST_ERR: if (w_err_ack) r_delta <= err_dat;
                ST_UPD: begin
                    // Last update slot (idx == N) belongs to the bias.
                    if (r_idx == IDXW'(N)) begin
                        r_b   <= w_bsat;
                        r_idx <= '0;
                    end else begin
                        r_w[w_eidx] <= w_wsat;
                        r_idx       <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
